// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front end. Issues word-aligned requests to
//               instruction memory under a credit limit, collects in-order
//               responses into a DEPTH-entry queue presented to decode, and
//               discards in-flight responses after a redirect (DRAIN state).
//               Optional feature macro FETCH_STALL_CNT_EN adds a saturating
//               32-bit decode-starvation counter output (stall_count).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_count
`endif
);

    // Counter widths: occupancy/outstanding counts reach DEPTH inclusive.
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
    localparam logic [c_PW-1:0] c_PTR_ONE   = c_PW'(1);
    localparam logic [c_PW-1:0] c_PTR_LAST  = c_PW'(DEPTH - 1);
    localparam logic [c_CW:0]   c_DEPTH_EXT = (c_CW + 1)'(DEPTH);

    // Fetch control states.
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [31:0]     r_pc;
    logic [c_CW-1:0] r_outstanding;
    logic [c_CW-1:0] w_out_next;
    logic [c_CW-1:0] r_drop;
    logic [c_CW-1:0] w_drop_next;
    logic [c_CW-1:0] r_count;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [31:0]     r_q_instr [DEPTH];
    logic [31:0]     r_q_pc    [DEPTH];

    logic            w_grant;
    logic            w_resp;
    logic            w_push;
    logic            w_pop;
    logic [c_CW:0]   w_level;
    logic [31:0]     w_out_bytes;
    logic [31:0]     w_resp_pc;
    logic            w_unused_redirect_lsbs;

    // Redirect targets are always word aligned; the low bits carry no meaning.
    assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

    // Circular pointer advance that also holds for non power-of-two depths.
    function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + c_PTR_ONE;
    endfunction

    // Credit rule: queue entries plus in-flight requests never exceed DEPTH,
    // so every response that comes back in RUN always has a queue slot.
    assign w_level   = {1'b0, r_count} + {1'b0, r_outstanding};
    assign imem_req  = (r_state == c_RUN) && !redirect && (w_level < c_DEPTH_EXT);
    assign imem_addr = r_pc;
    assign w_grant   = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign w_resp = imem_rvalid && (r_outstanding != '0);
    assign w_push = w_resp && (r_state == c_RUN) && !redirect;
    assign w_pop  = dec_valid && dec_ready && !redirect;

    // Responses are in order and all outstanding requests belong to the
    // current sequential stream, so the oldest one sits outstanding*4 bytes
    // behind the fetch PC (modulo 2^32, matching the PC wrap).
    assign w_out_bytes = {{(30 - c_CW){1'b0}}, r_outstanding, 2'b00};
    assign w_resp_pc   = r_pc - w_out_bytes;

    // Outstanding-request bookkeeping for the next edge.
    always_comb begin
        w_out_next = r_outstanding;
        if (w_grant && !w_resp) begin
            w_out_next = r_outstanding + c_CNT_ONE;
        end else if (!w_grant && w_resp) begin
            w_out_next = r_outstanding - c_CNT_ONE;
        end
    end

    // Next-state and drop-count logic for the fetch controller.
    always_comb begin
        w_state_next = r_state;
        w_drop_next  = r_drop;
        case (r_state)
            c_IDLE: begin
                w_state_next = c_RUN;
            end
            c_RUN: begin
                if (redirect) begin
                    w_drop_next = w_out_next;
                    if (w_out_next != '0) begin
                        w_state_next = c_DRAIN;
                    end
                end
            end
            c_DRAIN: begin
                if (redirect) begin
                    w_drop_next = w_out_next;
                end else if (w_resp && (r_drop != '0)) begin
                    w_drop_next = r_drop - c_CNT_ONE;
                end
                if (!redirect && (w_drop_next == '0)) begin
                    w_state_next = c_RUN;
                end
            end
            default: begin
                w_state_next = c_IDLE;
                w_drop_next  = '0;
            end
        endcase
    end

    // Controller state, drop count and outstanding count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_drop        <= '0;
            r_outstanding <= '0;
        end else begin
            r_state       <= w_state_next;
            r_drop        <= w_drop_next;
            r_outstanding <= w_out_next;
        end
    end

    // Fetch PC: redirect wins, otherwise advance by one word per grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= {RESET_PC[31:2], 2'b00};
        end else if (redirect) begin
            r_pc <= {redirect_pc[31:2], 2'b00};
        end else if (w_grant) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue at once.
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage; contents only matter while counted as valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= imem_rdata;
            r_q_pc[r_wr_ptr]    <= w_resp_pc;
        end
    end

    // Decode view of the queue head, forced to zero when empty.
    assign dec_valid = (r_count != '0);
    assign dec_instr = dec_valid ? r_q_instr[r_rd_ptr] : 32'h0;
    assign dec_pc    = dec_valid ? r_q_pc[r_rd_ptr]    : 32'h0;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] r_stall_count;

    // Count RUN cycles where decode wanted an instruction but none was ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if ((r_state == c_RUN) && dec_ready && !dec_valid &&
                     (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed bench for fetch_unit. A memory model answers grants
//               in order; expected decode entries go into a scoreboard queue
//               that an independent monitor drains and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready = 1'b0;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_valid   (dec_valid),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .dec_ready   (dec_ready)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int grant_cnt = 0;

    // Stimulus settings applied at the next step.
    logic        b_reset = 1'b1;
    logic        b_gnt = 1'b0;
    logic        b_rdy = 1'b0;
    logic        b_redir = 1'b0;
    logic [31:0] b_redir_pc = 32'h0;
    logic        b_rsp_en = 1'b1;

    // Memory model: granted addresses awaiting response, in order.
    logic [31:0] pend_addr[$];
    int          pend_cyc[$];
    bit          pend_stale[$];
    // Scoreboard of {pc, instr} expected at decode.
    logic [63:0] sb[$];
    logic [31:0] exp_pc = RESET_PC;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, then observe grants.
    task automatic step();
        logic [31:0] a;
        bit          stale;
        @(negedge clk);
        cyc++;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (b_rsp_en && (pend_addr.size() > 0) && (pend_cyc[0] < cyc)) begin
            a     = pend_addr.pop_front();
            void'(pend_cyc.pop_front());
            stale = pend_stale.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(a);
            if (!stale && !b_redir && !b_reset) begin
                sb.push_back({a, word_of(a)});
            end
        end
        reset       = b_reset;
        redirect    = b_redir;
        redirect_pc = b_redir_pc;
        imem_gnt    = b_gnt;
        dec_ready   = b_rdy;
        if (b_reset || b_redir) begin
            sb.delete();
            foreach (pend_stale[i]) pend_stale[i] = 1'b1;
        end
        if (b_reset) begin
            exp_pc = RESET_PC;
        end else if (b_redir) begin
            exp_pc = {b_redir_pc[31:2], 2'b00};
        end
        #1;
        if (b_redir && !b_reset) begin
            chk("no_req_on_redirect", 32'(imem_req), 32'd0);
        end
        if (!b_reset && (imem_req === 1'b1) && imem_gnt) begin
            chk("imem_addr", imem_addr, exp_pc);
            pend_addr.push_back(exp_pc);
            pend_cyc.push_back(cyc);
            pend_stale.push_back(1'b0);
            exp_pc = exp_pc + 32'd4;
            grant_cnt++;
        end
    endtask

    // Monitor: compare the decode head with the scoreboard, pop on consume.
    always @(negedge clk) begin
        #2;
        if (!reset && !redirect && (dec_valid === 1'b1)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL dec_unexpected: got pc %h instr %h expected none", dec_pc, dec_instr);
            end else begin
                chk("dec_pc", dec_pc, sb[0][63:32]);
                chk("dec_instr", dec_instr, sb[0][31:0]);
                if (dec_ready) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        b_reset = 1'b1; b_gnt = 1'b1; b_rdy = 1'b1; b_rsp_en = 1'b1;
        repeat (3) step();
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_instr", dec_instr, 32'd0);
        chk("rst_dec_pc", dec_pc, 32'd0);

        // Start-up latency and streaming
        b_reset = 1'b0;
        step(); chk("idle_no_req", 32'(imem_req), 32'd0);
        step(); chk("first_req", 32'(imem_req), 32'd1);
                chk("first_addr", imem_addr, RESET_PC);
        step(); chk("no_early_valid", 32'(dec_valid), 32'd0);
        step(); chk("first_dec_valid", 32'(dec_valid), 32'd1);
                chk("first_dec_pc", dec_pc, RESET_PC);
                chk("first_dec_instr", dec_instr, word_of(RESET_PC));
        repeat (8) step();

        // Backpressure: credit limit of DEPTH, then one request per pop
        b_gnt = 1'b0; repeat (6) step();
        chk("drained_valid", 32'(dec_valid), 32'd0);
        b_rdy = 1'b0; b_gnt = 1'b1; grant_cnt = 0;
        repeat (10) step();
        chk("bp_grants", 32'(grant_cnt), 32'd4);
        chk("bp_req_low", 32'(imem_req), 32'd0);
        b_rdy = 1'b1;
        step(); chk("bp_still_full", 32'(imem_req), 32'd0);
        step(); chk("bp_req_after_pop", 32'(imem_req), 32'd1);
        repeat (6) step();

        // Redirect with full queue and nothing outstanding
        b_rdy = 1'b0; repeat (8) step();
        chk("full_valid", 32'(dec_valid), 32'd1);
        b_redir = 1'b1; b_redir_pc = 32'h0000_0200; b_rdy = 1'b1;
        step();
        b_redir = 1'b0;
        step(); chk("flush_valid", 32'(dec_valid), 32'd0);
                chk("redir_req", 32'(imem_req), 32'd1);
                chk("redir_addr", imem_addr, 32'h0000_0200);
        repeat (6) step();

        // Redirect to unaligned target with two outstanding
        b_gnt = 1'b0; repeat (4) step();
        b_rsp_en = 1'b0; b_gnt = 1'b1; repeat (2) step();
        b_redir = 1'b1; b_redir_pc = 32'h0000_0103; step();
        b_redir = 1'b0;
        step(); chk("drain_no_req_a", 32'(imem_req), 32'd0);
                chk("drain_no_valid", 32'(dec_valid), 32'd0);
        step(); chk("drain_no_req_b", 32'(imem_req), 32'd0);
        b_rsp_en = 1'b1;
        step(); chk("drain_no_req_c", 32'(imem_req), 32'd0);
        step(); chk("drain_no_req_d", 32'(imem_req), 32'd0);
        step(); chk("post_drain_req", 32'(imem_req), 32'd1);
                chk("post_drain_addr", imem_addr, 32'h0000_0100);
        repeat (6) step();

        // Response coinciding with redirect, then redirect while draining
        b_rsp_en = 1'b0; step();
        b_rsp_en = 1'b1; b_redir = 1'b1; b_redir_pc = 32'h0000_0300; step();
        b_rsp_en = 1'b0; b_redir_pc = 32'h0000_0400; step();
        chk("drain_redirect_valid", 32'(dec_valid), 32'd0);
        b_redir = 1'b0; b_rsp_en = 1'b1;
        step(); chk("drain2_no_req", 32'(imem_req), 32'd0);
        step(); chk("redir2_req", 32'(imem_req), 32'd1);
                chk("redir2_addr", imem_addr, 32'h0000_0400);
        repeat (4) step();

        // Address wrap at the top of the address space
        b_redir = 1'b1; b_redir_pc = 32'hFFFF_FFF8; step();
        b_redir = 1'b0;
        step(); chk("wrap_a", imem_addr, 32'hFFFF_FFF8);
        step(); chk("wrap_b", imem_addr, 32'hFFFF_FFFC);
        step(); chk("wrap_c", imem_addr, 32'h0000_0000);
        repeat (5) step();

        // Reset mid-operation with outstanding requests and a queued entry
        b_gnt = 1'b0; repeat (4) step();
        b_rdy = 1'b0; b_rsp_en = 1'b0; b_gnt = 1'b1; repeat (4) step();
        b_rsp_en = 1'b1; step();
        b_rsp_en = 1'b0; b_reset = 1'b1; step();
        b_rsp_en = 1'b1;
        step(); chk("midrst_valid", 32'(dec_valid), 32'd0);
                chk("midrst_req", 32'(imem_req), 32'd0);
                chk("midrst_pc", dec_pc, 32'd0);
        step();
        b_reset = 1'b0; b_rdy = 1'b1;
        step(); chk("restart_idle", 32'(imem_req), 32'd0);
        step(); chk("restart_req", 32'(imem_req), 32'd1);
                chk("restart_addr", imem_addr, RESET_PC);
        step(); step();
        chk("restart_valid", 32'(dec_valid), 32'd1);
        chk("restart_dec_pc", dec_pc, RESET_PC);
        repeat (8) step();

        b_gnt = 1'b0; repeat (6) step();
        chk("sb_empty", 32'(sb.size()), 32'd0);

`ifdef FETCH_STALL_CNT_EN
        // Starvation counter over ten RUN cycles without grants
        b_reset = 1'b1; repeat (2) step();
        chk("stall_rst", stall_count, 32'd0);
        b_reset = 1'b0; b_gnt = 1'b0; b_rdy = 1'b1;
        step();
        repeat (10) step();
        step(); chk("stall_count", stall_count, 32'd10);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
